tick_sched: RTL

Multi-channel tick scheduler that shares one programmable base interval counter among several game processes (player motion, enemy motion, countdown display, and so on). Each channel divides the base tick by its own configurable divider and emits one-clock-wide `tick` pulses for use as clock enables. A small run/pause/stop state machine sequences the whole timebase. Channel dividers are written through a valid/ready configuration port.

---
 rtl/tick_sched_pkg.sv | 24 ++
 rtl/tick_sched_ch.sv | 53 +++++
 rtl/tick_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg
//   Shared types and constants for the tick scheduler.
//   - tick_sched_state_t : scheduler state encoding (IDLE/RUN/PAUSE)
//   - S_IDLE/S_RUN/S_PAUSE : the same encodings as plain 2-bit constants
//   - CW_DEF, DW_DEF     : default base-counter and divider widths
//   - ELAPSED_W          : width of the optional elapsed-event counter
//     (present only when TICK_SCHED_ELAPSED_EN is defined)
package tick_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } tick_sched_state_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam int CW_DEF    = 26;
    localparam int DW_DEF    = 8;
    localparam int ELAPSED_W = 16;

endpackage

// File: rtl/tick_sched_ch.sv
// tick_sched_ch
//   One tick channel: divides the shared base event by (div+1).
//   Ports:
//     clk, reset  : system clock, asynchronous active-high reset
//     en          : channel enable (level); low clears the counter
//     clear       : scheduler-wide counter clear (stop / state recovery)
//     wr, wr_div  : divider write strobe and value; a write also clears the counter
//     base_evt    : one-cycle base event from the shared base counter
//     tick        : registered one-cycle channel pulse
module tick_sched_ch #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    input  logic          wr,
    input  logic [DW-1:0] wr_div,
    input  logic          base_evt,
    output logic          tick
);

    logic [DW-1:0] div_q;
    logic [DW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            // Tick is a pulse: it only survives the cycle after a terminal count.
            tick_q <= 1'b0;
            if (wr) begin
                div_q <= wr_div;
            end
            if (clear || wr || !en) begin
                cnt_q <= '0;
            end else if (base_evt) begin
                if (cnt_q == div_q) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/tick_sched.sv
// tick_sched
//   Multi-channel tick scheduler. One programmable base counter produces a base
//   event every (base_max+1) RUN cycles; each channel divides that event by its
//   own divider and emits one-cycle tick pulses usable as clock enables.
//   Optional feature macro: TICK_SCHED_ELAPSED_EN adds a saturating 16-bit
//   count of base events on port 'elapsed'.
//   Ports:
//     clk, reset          : system clock, asynchronous active-high reset
//     base_max            : base interval (period base_max+1 cycles)
//     start/pause/stop    : command pulses, priority stop > pause > start
//     ch_en               : per-channel enable levels
//     cfg_valid/cfg_ready : divider write handshake; transfer when both high.
//                           cfg_ready is high whenever the scheduler is not in
//                           RUN; cfg_ch/cfg_div must be stable while cfg_valid
//                           is high, and a target index >= NUM_CH completes
//                           the handshake without writing anything.
//     cfg_ch, cfg_div     : write target channel and divider value
//     base_tick, tick     : registered base and channel pulses
//     state               : current scheduler state (debug/status)
//     elapsed             : (TICK_SCHED_ELAPSED_EN only) saturating event count
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = CW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [CW-1:0]                                   base_max,
    input  logic                                            start,
    input  logic                                            pause,
    input  logic                                            stop,
    input  logic [NUM_CH-1:0]                               ch_en,
    input  logic                                            cfg_valid,
    output logic                                            cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  cfg_ch,
    input  logic [DW-1:0]                                   cfg_div,
    output logic                                            base_tick,
    output logic [NUM_CH-1:0]                               tick,
    output logic [1:0]                                      state
`ifdef TICK_SCHED_ELAPSED_EN
    ,
    output logic [ELAPSED_W-1:0]                            elapsed
`endif
);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] base_cnt;
    logic          base_tick_q;
    logic          run_act;
    logic          base_evt;
    logic          clr_all;
    logic          cfg_fire;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // stop and pause outrank start even though both are no-ops here.
                if (!stop && !pause && start) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop)       state_d = S_IDLE;
                else if (pause) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (stop)       state_d = S_IDLE;
                else if (pause) state_d = S_RUN;
            end
            default: state_d = S_IDLE;   // illegal encoding recovers to IDLE
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Counting only happens in a RUN cycle that is not leaving RUN; this is what
    // keeps a pause or stop sampled at an edge from firing an event at that edge.
    assign run_act  = (state_q == S_RUN) && !stop && !pause;
    // '>=' lets a mid-run reduction of base_max reload at once instead of wrapping.
    assign base_evt = run_act && (base_cnt >= base_max);
    assign clr_all  = (stop && (state_q != S_IDLE)) || (state_q == 2'd3);

    // ---------------- base counter ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_cnt    <= '0;
            base_tick_q <= 1'b0;
        end else begin
            base_tick_q <= base_evt;
            if (clr_all) begin
                base_cnt <= '0;
            end else if (run_act) begin
                base_cnt <= base_evt ? '0 : base_cnt + 1'b1;
            end
        end
    end

    // ---------------- config decode ----------------
    assign cfg_ready = (state_q != S_RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic wr;
            // Only indices below NUM_CH exist, so out-of-range targets match nothing.
            assign wr = cfg_fire && (int'(cfg_ch) == gi);

            tick_sched_ch #(.DW(DW)) u_ch (
                .clk      (clk),
                .reset    (reset),
                .en       (ch_en[gi]),
                .clear    (clr_all),
                .wr       (wr),
                .wr_div   (cfg_div),
                .base_evt (base_evt),
                .tick     (tick[gi])
            );
        end
    endgenerate

`ifdef TICK_SCHED_ELAPSED_EN
    logic [ELAPSED_W-1:0] elapsed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elapsed_q <= '0;
        end else if (clr_all) begin
            elapsed_q <= '0;
        end else if (base_evt && (elapsed_q != {ELAPSED_W{1'b1}})) begin
            elapsed_q <= elapsed_q + 1'b1;
        end
    end

    assign elapsed = elapsed_q;
`endif

    assign base_tick = base_tick_q;
    assign state     = state_q;

endmodule
